// File: rtl/sram_rd_slave.sv
`timescale 1ns/1ps
// AXI read slave: serves one AR burst at a time from a single-port SRAM with
// one-cycle read latency, returning beats on R with the latched ID and RLAST.
//
// Handshakes: a channel transfers on the rising edge where VALID and READY are
// both 1; VALID never depends combinationally on READY, and the payload holds
// stable while VALID is high and READY is low.
module sram_rd_slave #(
  parameter int MEM_AW = 14,
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   ARID,
  input  logic [ADDR_W-1:0] ARADDR,
  input  logic [LEN_W-1:0]  ARLEN,
  input  logic [SIZE_W-1:0] ARSIZE,
  input  logic [1:0]        ARBURST,
  input  logic              ARVALID,
  output logic              ARREADY,
  output logic [ID_W-1:0]   RID,
  output logic [DATA_W-1:0] RData,
  output logic [1:0]        RResp,
  output logic              RLast,
  output logic              RValid,
  input  logic              RReady,
  output logic              mem_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    LOAD = 2'd2,
    DATA = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q;
  logic [MEM_AW-1:0]   addr_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    cnt_q;
  logic                fixed_q;
  logic [DATA_W-1:0]   rdata_q;

  logic ar_fire;
  logic r_fire;
  logic last;

  // Size, byte offset and upper address bits carry no meaning for this slave.
  logic unused_bits;
  assign unused_bits = ^{ARSIZE, ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

  assign last    = (cnt_q == len_q);
  assign ar_fire = ARVALID && ARREADY;
  assign r_fire  = RValid && RReady;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_fire) state_d = REQ;
      REQ:     state_d = LOAD;
      LOAD:    state_d = DATA;
      DATA:    if (r_fire) state_d = last ? IDLE : REQ;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      fixed_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (ar_fire) begin
        id_q    <= ARID;
        addr_q  <= ARADDR[MEM_AW+1:2];
        len_q   <= ARLEN;
        fixed_q <= (ARBURST == 2'b00);
        cnt_q   <= '0;
      end
      if (state_q == LOAD) rdata_q <= mem_rdata;
      // addr_q wraps naturally at the top of the SRAM.
      if (r_fire && !last) begin
        cnt_q <= cnt_q + LEN_W'(1);
        if (!fixed_q) addr_q <= addr_q + MEM_AW'(1);
      end
    end
  end

  // ARREADY is gated by rst so it reads 0 throughout reset.
  assign ARREADY   = rst && (state_q == IDLE);
  assign RValid    = (state_q == DATA);
  assign RLast     = RValid && last;
  assign RData     = rdata_q;
  assign RID       = id_q;
  assign RResp     = 2'b00;
  assign mem_en    = (state_q == REQ);
  assign mem_addr  = addr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_rd_slave.sv
`timescale 1ns/1ps
// Self-checking bench for sram_rd_slave: directed vector table, hand-written
// reset/back-to-back sequences, and random bursts against a burst-level model.
module tb_sram_rd_slave;

  localparam int MEM_AW = 14;
  localparam int DEPTH  = 1 << MEM_AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [7:0]        ARID = '0;
  logic [31:0]       ARADDR = '0;
  logic [3:0]        ARLEN = '0;
  logic [2:0]        ARSIZE = '0;
  logic [1:0]        ARBURST = '0;
  logic              ARVALID = 1'b0;
  logic              ARREADY;
  logic [7:0]        RID;
  logic [31:0]       RData;
  logic [1:0]        RResp;
  logic              RLast;
  logic              RValid;
  logic              RReady = 1'b0;
  logic              mem_en;
  logic [MEM_AW-1:0] mem_addr;
  logic [31:0]       mem_rdata = '0;
  logic [1:0]        dbg_state;

  sram_rd_slave #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst(rst),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RData(RData), .RResp(RResp), .RLast(RLast),
    .RValid(RValid), .RReady(RReady),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [31:0] mem [DEPTH];
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  int en_count = 0;
  logic [31:0]       exp_q[$];
  logic [MEM_AW-1:0] exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      check("ar_r_exclusive", 32'(ARREADY && RValid), 32'd0);
      if (mem_en) begin
        en_count++;
        if (exp_addr_q.size() == 0) check("mem_en_unexpected", 32'd1, 32'd0);
        else check("mem_addr", 32'(mem_addr), 32'(exp_addr_q.pop_front()));
      end
    end
  end

  // ---------------- reference model ----------------
  task automatic push_model(input logic [31:0] araddr, input int len, input logic [1:0] burst);
    int base;
    int w;
    base = int'(araddr[MEM_AW+1:2]);
    for (int i = 0; i <= len; i++) begin
      w = (burst == 2'b00) ? base : (base + i) % DEPTH;
      exp_addr_q.push_back(MEM_AW'(w));
      exp_q.push_back(mem[w]);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input bit keep);
    int n;
    n = 0;
    ARID = id; ARADDR = addr; ARLEN = 4'(len); ARBURST = burst;
    ARSIZE = 3'($urandom_range(0, 7));
    ARVALID = 1'b1;
    en_count = 0;
    while (!ARREADY && n < 20) begin tick(); n++; end
    check("ar_wait", 32'(n), 32'd0);
    tick();
    if (!keep) ARVALID = 1'b0;
  endtask

  // Waits for one beat, checks it, optionally stalls, optionally takes it.
  task automatic beat(input logic [7:0] id, input bit last, input int stall, input bit hs);
    int lat;
    int leak;
    logic [31:0] exp;
    lat = 1;
    leak = 0;
    while (!RValid && lat < 20) begin
      if (ARREADY) leak++;
      tick();
      lat++;
    end
    check("r_latency", 32'(lat), 32'd3);
    check("arready_busy", 32'(leak), 32'd0);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
    check("rdata", RData, exp);
    check("rid", 32'(RID), 32'(id));
    check("rlast", 32'(RLast), 32'(last));
    check("rresp", 32'(RResp), 32'd0);
    check("arready_in_data", 32'(ARREADY), 32'd0);
    if (stall > 0) begin
      RReady = 1'b0;
      repeat (stall) begin
        tick();
        check("hold_rvalid", 32'(RValid), 32'd1);
        check("hold_rdata", RData, exp);
        check("hold_rlast", 32'(RLast), 32'(last));
      end
      RReady = 1'b1;
    end
    if (hs) tick();
  endtask

  task automatic collect(input logic [7:0] id, input int len, input int stall0, input bit rand_stall);
    int s;
    for (int i = 0; i <= len; i++) begin
      s = rand_stall ? int'($urandom_range(0, 2)) : ((i == 0) ? stall0 : 0);
      beat(id, i == len, s, 1'b1);
    end
    check("idle_arready", 32'(ARREADY), 32'd1);
    check("idle_rvalid", 32'(RValid), 32'd0);
    check("mem_en_count", 32'(en_count), 32'(len + 1));
    check("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
  endtask

  task automatic reset_mid(input bit in_req);
    push_model(32'h200, 7, 2'b01);
    start_ar(8'h5C, 32'h200, 7, 2'b01, 1'b0);
    beat(8'h5C, 1'b0, 0, 1'b1);
    if (in_req) check("pre_rst_mem_en", 32'(mem_en), 32'd1);
    else beat(8'h5C, 1'b0, 0, 1'b0);
    rst = 1'b0;
    #1;
    check("rst_rvalid", 32'(RValid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_arready", 32'(ARREADY), 32'd0);
    check("rst_rlast", 32'(RLast), 32'd0);
    exp_q.delete();
    exp_addr_q.delete();
    repeat (2) tick();
    rst = 1'b1;
    #1;
    check("post_rst_arready", 32'(ARREADY), 32'd1);
    push_model(32'h44, 0, 2'b01);
    start_ar(8'hE1, 32'h44, 0, 2'b01, 1'b0);
    collect(8'hE1, 0, 0, 1'b0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic [7:0]               id;
    logic [31:0]              addr;
    int                       len;
    logic [1:0]               burst;
    int                       stall;
    logic [3:0][MEM_AW-1:0]   exp_addr;
    logic [3:0][31:0]         exp_data;
  } vec_t;

  vec_t vecs[4];

  task automatic set_vec(input int k, input logic [7:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input int stall,
                         input logic [MEM_AW-1:0] a0, a1, a2, a3,
                         input logic [31:0] d0, d1, d2, d3);
    vecs[k].id = id; vecs[k].addr = addr; vecs[k].len = len;
    vecs[k].burst = burst; vecs[k].stall = stall;
    vecs[k].exp_addr[0] = a0; vecs[k].exp_addr[1] = a1;
    vecs[k].exp_addr[2] = a2; vecs[k].exp_addr[3] = a3;
    vecs[k].exp_data[0] = d0; vecs[k].exp_data[1] = d1;
    vecs[k].exp_data[2] = d2; vecs[k].exp_data[3] = d3;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rid;
    logic [31:0] raddr;
    int          rlen;
    logic [1:0]  rburst;

    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA5A50000 | i;
    mem[16'h10] = 32'hDEADBEEF;
    mem[16'h40] = 32'd1; mem[16'h41] = 32'd2; mem[16'h42] = 32'd3; mem[16'h43] = 32'd4;

    set_vec(0, 8'h21, 32'h40, 0, 2'b01, 0, 14'h10, 14'h0, 14'h0, 14'h0,
            32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    set_vec(1, 8'h4A, 32'h100, 3, 2'b01, 2, 14'h40, 14'h41, 14'h42, 14'h43,
            32'd1, 32'd2, 32'd3, 32'd4);
    set_vec(2, 8'h93, 32'h8, 2, 2'b00, 0, 14'h2, 14'h2, 14'h2, 14'h0,
            32'hA5A50002, 32'hA5A50002, 32'hA5A50002, 32'h0);
    set_vec(3, 8'h7E, 32'hFFF8, 3, 2'b10, 0, 14'h3FFE, 14'h3FFF, 14'h0000, 14'h0001,
            32'hA5A53FFE, 32'hA5A53FFF, 32'hA5A50000, 32'hA5A50001);

    // reset state
    repeat (3) tick();
    check("rst_arready0", 32'(ARREADY), 32'd0);
    check("rst_rvalid0", 32'(RValid), 32'd0);
    check("rst_rlast0", 32'(RLast), 32'd0);
    check("rst_rdata0", RData, 32'd0);
    check("rst_rid0", 32'(RID), 32'd0);
    check("rst_rresp0", 32'(RResp), 32'd0);
    check("rst_mem_en0", 32'(mem_en), 32'd0);
    check("rst_mem_addr0", 32'(mem_addr), 32'd0);
    rst = 1'b1;
    #1;
    check("release_arready", 32'(ARREADY), 32'd1);
    RReady = 1'b1;

    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i <= vecs[v].len; i++) begin
        exp_addr_q.push_back(vecs[v].exp_addr[i]);
        exp_q.push_back(vecs[v].exp_data[i]);
      end
      start_ar(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].burst, 1'b0);
      collect(vecs[v].id, vecs[v].len, vecs[v].stall, 1'b0);
    end

    reset_mid(1'b0);
    reset_mid(1'b1);

    // ARVALID held through a 2-beat burst, then a back-to-back burst
    push_model(32'h300, 1, 2'b01);
    start_ar(8'h33, 32'h300, 1, 2'b01, 1'b1);
    ARID = 8'hC4; ARADDR = 32'h404; ARLEN = 4'd0; ARBURST = 2'b01;
    collect(8'h33, 1, 0, 1'b0);
    push_model(32'h404, 0, 2'b01);
    start_ar(8'hC4, 32'h404, 0, 2'b01, 1'b0);
    collect(8'hC4, 0, 0, 1'b0);

    // random bursts against the model
    for (int i = 0; i < 200; i++) mem[$urandom_range(0, DEPTH - 1)] = $urandom;
    for (int k = 0; k < 40; k++) begin
      rid    = 8'($urandom);
      raddr  = $urandom;
      rlen   = int'($urandom_range(0, 15));
      rburst = 2'($urandom_range(0, 3));
      push_model(raddr, rlen, rburst);
      start_ar(rid, raddr, rlen, rburst, 1'b0);
      collect(rid, rlen, 0, 1'b1);
      repeat (int'($urandom_range(0, 2))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
